// File: rtl/ctrl_fsm_p.sv
// ctrl_fsm_p: multi-cycle processor control unit (fetch, decode, execute, halt)
module ctrl_fsm_p #(
  parameter int D_AW = 8,
  parameter int RF_AW = 4,
  parameter int LOAD_WAIT = 1,
  localparam int INST_W = 4 + D_AW + RF_AW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [INST_W-1:0] Inst,
  input  logic              RA_zero,
  input  logic              Resume,
  output logic              PC_clr,
  output logic              PC_up,
  output logic              PC_ld,
  output logic [D_AW-1:0]   PC_Addr,
  output logic              IR_ld,
  output logic [D_AW-1:0]   D_Addr,
  output logic              D_Wr,
  output logic [1:0]        RF_s,
  output logic [D_AW-1:0]   RF_Imm,
  output logic [RF_AW-1:0]  RF_Ra_Addr,
  output logic [RF_AW-1:0]  RF_Rb_Addr,
  output logic [RF_AW-1:0]  RF_W_Addr,
  output logic              RF_W_en,
  output logic [2:0]        ALU_s0,
  output logic              Halted,
  output logic              Illegal,
  output logic [15:0]       Instr_cnt,
  output logic [3:0]        STATE
);
  typedef enum logic [3:0] {
    s_init = 4'd0, s_fetch = 4'd1, s_decode = 4'd2, s_noop = 4'd3,
    s_load_a = 4'd4, s_load_b = 4'd5, s_store = 4'd6, s_add = 4'd7,
    s_sub = 4'd8, s_halt = 4'd9, s_ldi = 4'd10, s_jpz = 4'd11
  } state_t;
  localparam logic [2:0] WAIT_LAST = 3'(LOAD_WAIT - 1);
  state_t state;
  logic [2:0] wait_cnt;
  logic [3:0] opcode;
  logic [RF_AW-1:0] f_t, f_b, f_w;
  logic [D_AW-1:0] f_m, f_l;
  logic is_load, is_alu, retire;
  assign opcode = Inst[INST_W-1 -: 4];
  assign f_t = Inst[D_AW+RF_AW-1 -: RF_AW];
  assign f_m = Inst[D_AW+RF_AW-1 -: D_AW];
  assign f_l = Inst[D_AW-1:0];
  assign f_b = Inst[D_AW-1 -: RF_AW];
  assign f_w = Inst[RF_AW-1:0];
  assign is_load = state == s_load_a || state == s_load_b;
  assign is_alu = state == s_add || state == s_sub;
  assign retire = (state inside {s_noop, s_load_b, s_store, s_add, s_sub, s_ldi, s_jpz})
                  || (state == s_halt && Resume);
  always_ff @(negedge Clock) begin
    if (!Reset) begin
      state <= s_init;
      PC_clr <= 1'b1;
      Illegal <= 1'b0;
      Instr_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      PC_clr <= 1'b0;
      if (retire && Instr_cnt != 16'hFFFF) Instr_cnt <= Instr_cnt + 16'd1;
      case (state)
        s_init, s_noop, s_load_b, s_store, s_add, s_sub, s_ldi, s_jpz: state <= s_fetch;
        s_fetch: state <= s_decode;
        s_decode: begin
          wait_cnt <= '0;
          case (opcode)
            4'd0: state <= s_noop;
            4'd1: state <= s_store;
            4'd2: state <= s_load_a;
            4'd3: state <= s_add;
            4'd4: state <= s_sub;
            4'd5: state <= s_halt;
            4'd6: state <= s_ldi;
            4'd7: state <= s_jpz;
            default: begin
              state <= s_fetch;
              Illegal <= 1'b1;
            end
          endcase
        end
        s_load_a: begin
          wait_cnt <= wait_cnt == WAIT_LAST ? '0 : wait_cnt + 3'd1;
          if (wait_cnt == WAIT_LAST) state <= s_load_b;
        end
        s_halt: if (Resume) state <= s_fetch;
        default: state <= s_init;
      endcase
    end
  end
  // Datapath controls are pure decodes of the current state and the IR fields
  assign PC_up = state == s_fetch;
  assign IR_ld = state == s_fetch;
  assign PC_ld = state == s_jpz && RA_zero;
  assign PC_Addr = state == s_jpz ? f_l : '0;
  assign D_Addr = is_load ? f_m : state == s_store ? f_l : '0;
  assign D_Wr = state == s_store;
  assign RF_s = is_load ? 2'd1 : state == s_ldi ? 2'd2 : 2'd0;
  assign RF_Imm = state == s_ldi ? f_m : '0;
  assign RF_Ra_Addr = (state == s_store || is_alu || state == s_jpz) ? f_t : '0;
  assign RF_Rb_Addr = is_alu ? f_b : '0;
  assign RF_W_Addr = (is_load || is_alu || state == s_ldi) ? f_w : '0;
  assign RF_W_en = state == s_load_b || is_alu || state == s_ldi;
  assign ALU_s0 = state == s_add ? 3'd1 : state == s_sub ? 3'd2 : 3'd0;
  assign Halted = state == s_halt;
  assign STATE = state;
endmodule

// File: doc/ctrl_fsm_p.md
CTRL_FSM_P -- requirements
Module: ctrl_fsm_p

Interface
REQ-001 Parameter D_AW, default 8, data-memory and PC address width.
REQ-002 Parameter RF_AW, default 4, register-file address width; legal only when 2*RF_AW <= D_AW.
REQ-003 Parameter LOAD_WAIT, default 1, data-memory read latency in cycles; legal range 1-4.
REQ-004 Derived INST_W = 4 + D_AW + RF_AW, which is 16 at defaults.
REQ-005 Clock  in  1  system clock; all state changes on the falling edge.
REQ-006 Reset  in  1  synchronous, active-low; 0 = reset.
REQ-007 Inst  in  INST_W  instruction from the IR; opcode = Inst[INST_W-1:INST_W-4].
REQ-008 RA_zero  in  1  high when register-file port A data equals zero.
REQ-009 Resume  in  1  leave HALT.
REQ-010 PC_clr  out  1  registered PC clear.
REQ-011 PC_up / PC_ld  out  1 each  PC increment / PC parallel load.
REQ-012 PC_Addr  out  D_AW  jump target.
REQ-013 IR_ld  out  1  instruction register load.
REQ-014 D_Addr  out  D_AW; D_Wr  out  1  data-memory address and write enable.
REQ-015 RF_s  out  2  write-data mux select: 0 ALU, 1 memory, 2 immediate.
REQ-016 RF_Imm  out  D_AW  immediate data.
REQ-017 RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  out  RF_AW each; RF_W_en  out  1.
REQ-018 ALU_s0  out  3  ALU function: 0 pass, 1 add, 2 sub.
REQ-019 Halted  out  1  high while in HALT.
REQ-020 Illegal  out  1  sticky illegal-opcode flag.
REQ-021 Instr_cnt  out  16  retired-instruction count.
REQ-022 STATE  out  4  current state code.

Function
Field names: T = Inst[D_AW+RF_AW-1:D_AW]; M = Inst[D_AW+RF_AW-1:RF_AW]; L = Inst[D_AW-1:0]; B = Inst[D_AW-1:D_AW-RF_AW]; W = Inst[RF_AW-1:0].
REQ-023 States and codes: Init 0, Fetch 1, Decode 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, LDI 10, JPZ 11.
REQ-024 Outputs are decoded from the state and Inst only; every output not listed for a state is 0.
REQ-025 Init: next state Fetch.
REQ-026 Fetch: PC_up=1, IR_ld=1; next state Decode.
REQ-027 Decode, by opcode: 0 NOOP, 1 STORE, 2 LOAD_A, 3 ADD, 4 SUB, 5 HALT, 6 LDI, 7 JPZ; opcodes 8-15 go to Fetch and set Illegal.
REQ-028 NOOP: next state Fetch.
REQ-029 LOAD_A: D_Addr=M, RF_s=1, RF_W_Addr=W; held for exactly LOAD_WAIT cycles by an internal counter, then LOAD_B.
REQ-030 LOAD_B: as LOAD_A plus RF_W_en=1; next state Fetch.
REQ-031 STORE: RF_Ra_Addr=T, D_Addr=L, D_Wr=1; next state Fetch.
REQ-032 ADD: RF_Ra_Addr=T, RF_Rb_Addr=B, RF_W_Addr=W, RF_W_en=1, ALU_s0=1; next state Fetch.
REQ-033 SUB: same as ADD except ALU_s0=2.
REQ-034 LDI: RF_s=2, RF_Imm=M, RF_W_Addr=W, RF_W_en=1; next state Fetch.
REQ-035 JPZ: RF_Ra_Addr=T, PC_Addr=L, PC_ld=RA_zero; next state Fetch.
REQ-036 HALT: Halted=1; stay in HALT until Resume=1 is sampled, then Fetch; the PC is not modified.
REQ-037 Unused state codes 12-15 go to Init with all outputs 0.
REQ-038 Instr_cnt increments by 1 on each edge leaving NOOP, LOAD_B, STORE, ADD, SUB, LDI, JPZ or HALT; it saturates at 16'hFFFF.
REQ-039 Illegal remains 1 until reset; later legal instructions do not clear it.

Reset
REQ-040 An edge sampling Reset=0 sets the state to Init, PC_clr=1, Illegal=0, Instr_cnt=0 and clears the load counter; this takes priority over Resume and over any operation in progress, including mid-LOAD and in HALT.
REQ-041 PC_clr returns to 0 on the first edge that samples Reset=1; the state then advances Init -> Fetch.

Verification
REQ-042 Reset low for 2 edges, then high -> STATE 0, PC_clr=1, all other outputs 0; after release STATE goes 0 -> 1 -> 2.
REQ-043 Inst=16'h21A0 with LOAD_WAIT=3 -> LOAD_A held 3 cycles with D_Addr=8'h1A, RF_W_Addr=0, RF_s=1; then 1 LOAD_B cycle with RF_W_en=1; Instr_cnt +1.
REQ-044 Inst=16'h3A2B -> ADD state: Ra=A, Rb=2, W=B, ALU_s0=1, RF_W_en=1; Inst=16'h6FF3 -> LDI: RF_Imm=8'hFF, RF_s=2, W=3.
REQ-045 Inst=16'h7240 with RA_zero=1 -> PC_ld=1, PC_Addr=8'h40; with RA_zero=0 -> PC_ld=0; both return to Fetch.
REQ-046 Inst=16'h5000 -> HALT held for 10 cycles with Halted=1; Resume=1 -> Fetch; Resume=1 together with Reset=0 -> Init.
REQ-047 Inst=16'hF000 -> Decode goes to Fetch, Illegal=1 persists through later legal instructions; Reset=0 clears it.
